clkdiv_ctrl: RTL

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_pkg.sv | 16 +
 rtl/clkdiv_core.sv | 58 +++++
 rtl/clkdiv_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and constants for the clock divider controller.
package clkdiv_pkg;

  // Controller states: idle, clocking, and finishing the current period.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // Smallest usable divide ratio; ratios 0 and 1 are promoted to this.
  localparam int DIV_MIN       = 2;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 100;

endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: period counter plus registered clkout/tick generation.
// The run and ratio inputs are the values that will be in force during the
// next clkin cycle. That lets clkout_q and tick_q line up with the count
// held in cnt_q, so tick is high exactly on the last cycle of each period.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clkin,
  input  logic             clrn,
  input  logic             run,
  input  logic [WIDTH-1:0] ratio,
  output logic             clkout,
  output logic             tick
);

  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] half_n;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  // Next count: restart at 0 on the first running cycle and after each wrap.
  always_comb begin
    n_eff    = (ratio < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : ratio;
    half_n   = n_eff >> 1;
    last_cnt = n_eff - WIDTH'(1);
    run_d    = run;
    cnt_d    = '0;
    if (run && run_q && !tick_q) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    clkout_d = run && (cnt_d < half_n);
    tick_d   = run && (cnt_d == last_cnt);
  end

  // Counter and output flops; reset clears everything, even mid-period.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: start/stop controlled clock divider with a double-buffered
// divide ratio. A new ratio is held pending and becomes active in IDLE on
// the next cycle, or while running only at a period wrap. div_ack is a
// registered pulse on the first cycle the new ratio is in force.
// Optional feature macro CLKDIV_BURST_EN: when defined, a run ends by itself
// after burst_len periods (burst_len = 0 means run until stop).
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DIV_DEFAULT = DEFAULT_DIV
) (
  input  logic             clkin,
  input  logic             clrn,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  input  logic [WIDTH-1:0] burst_len,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             activate;
  logic             core_tick;

`ifdef CLKDIV_BURST_EN
  logic [WIDTH-1:0] burst_q, burst_d;
  logic [WIDTH-1:0] periods_q, periods_d;
`else
  logic             burst_len_unused;
  assign burst_len_unused = ^burst_len;
`endif

  // Next-state, ratio handover and registered output decode.
  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
`ifdef CLKDIV_BURST_EN
    burst_d    = burst_q;
    periods_d  = periods_q;
`endif
    activate = pend_q && ((state_q == IDLE) || core_tick);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
`ifdef CLKDIV_BURST_EN
          burst_d   = burst_len;
          periods_d = '0;
`endif
        end
      end
      RUN: begin
        if (core_tick) begin
          if (stop) begin
            state_d = IDLE;
          end
`ifdef CLKDIV_BURST_EN
          else if ((burst_q != '0) && ((periods_q + WIDTH'(1)) == burst_q)) begin
            state_d = IDLE;
          end else begin
            periods_d = periods_q + WIDTH'(1);
          end
`endif
        end else if (stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (core_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The old pending value is consumed first so a coinciding load stays pending.
    if (activate) begin
      ratio_d = pend_val_q;
      pend_d  = 1'b0;
    end
    if (div_load) begin
      pend_val_d = div_val;
      pend_d     = 1'b1;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_q != IDLE) && (state_d == IDLE);
    ack_d  = activate;
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      ratio_q    <= WIDTH'(DIV_DEFAULT);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
`ifdef CLKDIV_BURST_EN
      burst_q    <= '0;
      periods_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
`ifdef CLKDIV_BURST_EN
      burst_q    <= burst_d;
      periods_q  <= periods_d;
`endif
    end
  end

  clkdiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clkin  (clkin),
    .clrn   (clrn),
    .run    (busy_d),
    .ratio  (ratio_d),
    .clkout (clkout),
    .tick   (core_tick)
  );

  assign tick    = core_tick;
  assign busy    = busy_q;
  assign done    = done_q;
  assign div_ack = ack_q;

endmodule
